// File: rtl/alu_pkg.sv
// Shared ALU definitions: 3-bit op encodings used by the ALU, the datapath decoder
// and the multiply sequencer, plus the sequencer's state enum.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD  = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    DONE = 3'd4
  } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows the shared ALU (ADD/SLL/SRL) and stops
// as soon as the remaining multiplier bits are all zero.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] product_q, product_d;

  // Early termination: once the remaining multiplier is zero, nothing more can be added.
  function automatic mul_state_e next_for_q(input logic [WIDTH-1:0] q);
    if (q == '0)
      return DONE;
    else if (q[0])
      return ADD;
    else
      return SHL;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    alu_req = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = ALU_ADD;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = op_a;
          q_d     = op_b;
          acc_d   = '0;
          state_d = next_for_q(op_b);
        end
      end
      ADD: begin
        alu_req = 1'b1;
        alu_a   = acc_q;
        alu_b   = m_q;
        alu_op  = ALU_ADD;
        acc_d   = alu_result;
        state_d = SHL;
      end
      SHL: begin
        alu_req = 1'b1;
        alu_a   = m_q;
        alu_b   = WIDTH'(1);
        alu_op  = ALU_SLL;
        m_d     = alu_result;
        state_d = SHR;
      end
      SHR: begin
        alu_req = 1'b1;
        alu_a   = q_q;
        alu_b   = WIDTH'(1);
        alu_op  = ALU_SRL;
        q_d     = alu_result;
        state_d = next_for_q(alu_result);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Product is captured on entry to DONE so it is already valid while done is high.
  always_comb begin
    product_d = product_q;
    if (state_d == DONE)
      product_d = acc_d;
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomised bench for alu_mul_sequencer with a behavioural ALU wired to its alu_* ports.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        alu_req;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;

  int n_vec;
  int n_err;

  alu_mul_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_req    (alu_req),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The shared ALU as it lives in the datapath.
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_SLL: alu_result = alu_a << alu_b[4:0];
      ALU_SRL: alu_result = alu_a >> alu_b[4:0];
      default: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
    endcase
  end

  // Run one multiplication; extra start pulses are driven during cycles s1/s2.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int s1, input int s2);
    logic [2:0]  exp_ops[$];
    logic [31:0] exp_prod;
    int          exp_lat;
    int          top;
    bit          seen_done;
    logic [2:0]  e;

    exp_prod = a * b;
    top = -1;
    for (int i = 0; i < 32; i++) if (b[i]) top = i;
    exp_lat = 1;
    for (int i = 0; i <= top; i++) begin
      exp_lat += 2 + int'(b[i]);
      if (b[i]) exp_ops.push_back(3'b000);
      exp_ops.push_back(3'b101);
      exp_ops.push_back(3'b110);
    end

    if (busy !== 1'b0) begin
      for (int w = 0; w < 200 && busy !== 1'b0; w++) @(negedge clk);
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_wait: busy=%b required 0", busy);
      end
    end
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);

    seen_done = 1'b0;
    for (int n = 1; n <= 120 && !seen_done; n++) begin
      @(negedge clk);
      start = (n == s1) || (n == s2);
      op_a  = $urandom;
      op_b  = $urandom;
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_run: cycle %0d busy=%b required 1", n, busy);
      end
      if (alu_req === 1'b1) begin
        e = (exp_ops.size() > 0) ? exp_ops.pop_front() : 3'bxxx;
        n_vec++;
        if (alu_op !== e) begin
          n_err++;
          $display("FAIL alu_op_seq: a=%h b=%h cycle %0d op=%b required %b", a, b, n, alu_op, e);
        end
        if (alu_op == 3'b101 || alu_op == 3'b110) begin
          n_vec++;
          if (alu_b !== 32'd1) begin
            n_err++;
            $display("FAIL shift_b: cycle %0d alu_b=%h required 1", n, alu_b);
          end
        end
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        n_vec++;
        if (n != exp_lat) begin
          n_err++;
          $display("FAIL latency: a=%h b=%h done at %0d required %0d", a, b, n, exp_lat);
        end
        n_vec++;
        if (product !== exp_prod) begin
          n_err++;
          $display("FAIL product: a=%h b=%h got %h required %h", a, b, product, exp_prod);
        end
        n_vec++;
        if (exp_ops.size() != 0 || alu_req !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
          n_err++;
          $display("FAIL done_alu: ops_left=%0d alu_req=%b alu_a=%h alu_b=%h required 0", exp_ops.size(), alu_req, alu_a, alu_b);
        end
      end
    end
    start = 1'b0;
    if (!seen_done) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: a=%h b=%h no done within 120 cycles, required at %0d", a, b, exp_lat);
      return;
    end

    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== exp_prod) begin
      n_err++;
      $display("FAIL after_done: done=%b busy=%b product=%h required 0 0 %h", done, busy, product, exp_prod);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0 || alu_req !== 1'b0 ||
        alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'b000) begin
      n_err++;
      $display("FAIL %s: busy=%b done=%b product=%h alu_req=%b alu_a=%h alu_b=%h alu_op=%b required all 0",
               tag, busy, done, product, alu_req, alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    #12;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_release");
  endtask

  task automatic test_basic;
    run_op(32'd7, 32'd3, 0, 0);
    run_op(32'h0000_1234, 32'd0, 0, 0);
  endtask

  task automatic test_boundaries;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(32'h8000_0000, 32'd2, 0, 0);
    run_op(32'h0000_0000, 32'h8000_0001, 0, 0);
  endtask

  task automatic test_back_to_back;
    run_op(32'h0001_0203, 32'd5, 2, 7);
    run_op(32'hDEAD_BEEF, 32'd6, 0, 0);
  endtask

  task automatic test_reset_mid;
    run_op(32'h0000_00AB, 32'd3, 0, 0);
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'h0000_0123;
    op_b  = 32'h0000_00FF;
    @(posedge clk);
    for (int n = 1; n < 4; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_abort: done=%b busy=%b required 0 0", done, busy);
      end
    end
    run_op(32'h0000_0123, 32'h0000_00FF, 0, 0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_op(a, b, 0, 0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle 32-bit multiplier built on the shared ALU, with no dedicated multiplier hardware. It sequences the ALU through ADD, SLL and SRL operations to compute the low 32 bits of a×b using shift-and-add with early termination. It sits beside the single-cycle datapath. While `alu_req` is high, the CPU-side mux routes `alu_a`, `alu_b` and `alu_op` into the ALU and returns the ALU result on `alu_result`.

## Interface
- `WIDTH`, 32: operand/product width; ALU shift amount uses the low 5 bits.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op_a`  in  32  multiplicand, latched on accepted start.
- `op_b`  in  32  multiplier, latched on accepted start.
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1  one-cycle pulse; `product` is valid from this cycle.
- `product`  out  32  low 32 bits of a×b, held until the next accepted start.
- `alu_req`  out  1  high in ADD/SHL/SHR; the datapath must hand the ALU to this block.
- `alu_a`  out  32  ALU input1.
- `alu_b`  out  32  ALU input2.
- `alu_op`  out  3  ALU control: ADD=3'b000, SLL=3'b101, SRL=3'b110.
- `alu_result`  in  32  ALU output, combinational, same cycle.

## Operation
- Registers: `M` (multiplicand), `Q` (multiplier), `ACC` (accumulator), state.
- States:
  - IDLE: waits for `start`.
  - ADD: `ACC`←`ACC`+`M`.
  - SHL: `M`←`M`<<1.
  - SHR: `Q`←`Q`>>1.
  - DONE: `product`←`ACC`, `done`=1.
- IDLE, start=1: `M`←`op_a`, `Q`←`op_b`, `ACC`←0. Next state: DONE if `op_b`==0, else ADD if `op_b[0]`, else SHL.
- ADD: `alu_a`=`ACC`, `alu_b`=`M`, `alu_op`=ADD; `ACC`←`alu_result`; next state SHL.
- SHL: `alu_a`=`M`, `alu_b`=1, `alu_op`=SLL; `M`←`alu_result`; next state SHR.
- SHR: `alu_a`=`Q`, `alu_b`=1, `alu_op`=SRL; `Q`←`alu_result`. Next state is chosen from `alu_result`: DONE if 0, else ADD if bit 0 is set, else SHL.
- DONE: `product` is written with `ACC`; always returns to IDLE.
- IDLE/DONE ALU drive: `alu_a`=0, `alu_b`=0, `alu_op`=ADD.
- Arithmetic is modulo 2^32; overflow bits are discarded. The low 32 bits are identical for signed and unsigned operands, so there is no sign handling.
- `start` while busy is ignored, not queued. `start` in the DONE cycle is ignored; accepting requires IDLE.
- ALU outputs are combinational decodes of the registered state only. They never depend on `start` or `op_*`.

## Timing
- Reset (asynchronous, `rst_n`=0): state=IDLE, `M`=`Q`=`ACC`=0, `product`=0, `busy`=0, `done`=0, `alu_req`=0, `alu_a`=`alu_b`=0, `alu_op`=ADD.
- Reset mid-operation aborts immediately. There is no `done` pulse, and `product` returns to 0.
- Latency: start is accepted at edge 0. If `op_b` has its highest set bit at index k, then `done` is high in cycle 1 + Σ_{i=0..k}(2+b_i).
  - `op_b`=0: `done` is high in cycle 1.
  - Worst case, `op_b`=0xFFFFFFFF: 97 cycles.
- `done` lasts exactly 1 cycle; `busy` falls in the following cycle.
- A back-to-back start is accepted at the earliest at the edge where state=IDLE. The minimum issue interval is therefore latency+1.
- `alu_req` is high only in ADD/SHL/SHR. The ALU round trip (`alu_a`/`alu_b`/`alu_op` to `alu_result`) is combinational within one cycle.

## Structure
- Shared package `alu_pkg` holds:
  - ALU op constants (ADD..SRA, 3-bit), shared with the ALU and datapath decoder.
  - State enum {IDLE, ADD, SHL, SHR, DONE}.
- No sub-module. The ALU is not instantiated here; it stays in the datapath, behind a 2:1 mux selected by `alu_req`.
- The bench instantiates the ALU directly and wires it to the `alu_*` ports.

## Test plan
- `op_a`=7, `op_b`=3 → states ADD,SHL,SHR,ADD,SHL,SHR,DONE; `done` in cycle 7; `product`=21.
- `op_a`=0x1234, `op_b`=0 → `done` in cycle 1, `product`=0, `alu_req` never high.
- `op_a`=0xFFFFFFFF, `op_b`=0xFFFFFFFF → `done` in cycle 97, `product`=0x00000001; `op_a`=0x80000000, `op_b`=2 → `product`=0 (wrap).
- `start` pulsed in cycles 2 and 7 of a `op_b`=5 run → both ignored; one `done`, `product`=5×`op_a`; a start in the following IDLE cycle is accepted.
- `rst_n` asserted at cycle 4 of a `op_b`=0xFF run → all outputs at reset values immediately; no `done`; a new start after release gives the correct product.
- Every cycle with `alu_req`=1 → `alu_op`∈{000,101,110}, and shifts have `alu_b`=1; 1000 random operands match a×b mod 2^32.
